// File: rtl/aes_round_tail.sv
// AES round tail: ShiftRows -> MixColumns (bypassed on the last round) -> AddRoundKey,
// two registered stages with valid/ready on both sides. `AES_RT_BLKCNT_EN adds blk_cnt.
module aes_round_tail #(
    parameter int unsigned DW           = 128,
    parameter bit          KEEP_KEY_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sb_valid,
    output logic          sb_ready,
    input  logic [DW-1:0] sb_data,
    input  logic [DW-1:0] round_key,
    input  logic          last_round,
    output logic          rt_valid,
    input  logic          rt_ready,
    output logic [DW-1:0] rt_data
`ifdef AES_RT_BLKCNT_EN
    ,
    output logic [15:0]   blk_cnt
`endif
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Byte i of the state lives at [DW-1-8i -: 8]
    function automatic logic [DW-1:0] shift_rows(input logic [DW-1:0] s);
        logic [DW-1:0] o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                o[DW-1-8*(r+4*c) -: 8] = s[DW-1-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    // Shared-xor form: b_r = a_r ^ t ^ xtime(a_r ^ a_(r+1)), t = a0^a1^a2^a3
    function automatic logic [DW-1:0] mix_columns(input logic [DW-1:0] s);
        logic [DW-1:0] o;
        logic [7:0]    a0, a1, a2, a3, t;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[DW-1-8*(4*c)   -: 8];
            a1 = s[DW-1-8*(4*c+1) -: 8];
            a2 = s[DW-1-8*(4*c+2) -: 8];
            a3 = s[DW-1-8*(4*c+3) -: 8];
            t  = a0 ^ a1 ^ a2 ^ a3;
            o[DW-1-8*(4*c)   -: 8] = a0 ^ t ^ xtime(a0 ^ a1);
            o[DW-1-8*(4*c+1) -: 8] = a1 ^ t ^ xtime(a1 ^ a2);
            o[DW-1-8*(4*c+2) -: 8] = a2 ^ t ^ xtime(a2 ^ a3);
            o[DW-1-8*(4*c+3) -: 8] = a3 ^ t ^ xtime(a3 ^ a0);
        end
        return o;
    endfunction

    logic          s1_valid;
    logic [DW-1:0] s1_sr;
    logic          s1_last;
    logic          s2_valid;
    logic [DW-1:0] s2_key;
    logic [DW-1:0] s2_mix;
    logic          adv2;
    logic          in_xfer;

    always_comb begin
        adv2     = s1_valid & (~s2_valid | rt_ready);
        sb_ready = ~s1_valid | adv2;
        in_xfer  = sb_valid & sb_ready;
        s2_mix   = s1_last ? s1_sr : mix_columns(s1_sr);
        rt_valid = s2_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sr    <= '0;
            s1_last  <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_sr    <= shift_rows(sb_data);
            s1_last  <= last_round;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    generate
        if (KEEP_KEY_REG) begin : g_key_reg
            logic [DW-1:0] s1_key;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_key <= '0;
                end else if (in_xfer) begin
                    s1_key <= round_key;
                end
            end
            always_comb s2_key = s1_key;
        end else begin : g_key_live
            always_comb s2_key = round_key;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            rt_data  <= '0;
        end else if (adv2) begin
            s2_valid <= 1'b1;
            rt_data  <= s2_mix ^ s2_key;
        end else if (rt_ready) begin
            s2_valid <= 1'b0;
        end
    end

`ifdef AES_RT_BLKCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt <= '0;
        end else if (rt_valid && rt_ready && (blk_cnt != 16'hFFFF)) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

endmodule
